// File: rtl/bist_pkg.sv
// Shared definitions for the BIST vector engine: controller states, MISR
// polynomial and seed, test-word field positions, and the MISR step function.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } bist_state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    localparam int STIM_MSB    = 9;
    localparam int STIM_LSB    = 2;
    localparam int COMPACT_BIT = 0;

    // One MISR step: shift left, fold in the polynomial on carry-out, XOR the response byte.
    function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [7:0] data);
        logic [15:0] shifted;
        shifted = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000);
        return shifted ^ {8'h00, data};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register with a seed load and a step enable.
// Seed load has priority over stepping so a new run always starts from MISR_SEED.
module bist_misr
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic        step_en,
    input  logic [7:0]  data,
    output logic [15:0] sig
);

    // Signature register: reseed on reset or load, otherwise compact when enabled.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            sig <= MISR_SEED;
        end else if (step_en) begin
            sig <= misr_next(sig, data);
        end
    end

endmodule

// File: rtl/bist_vector_engine.sv
// BIST vector engine: buffers TAP-captured test words, replays them to the DUT
// on a run command and compacts the responses into a 16-bit MISR signature.
// Optional feature macro: BIST_GOLDEN_CMP_EN adds gold_sig input and pass output.
module bist_vector_engine
    import bist_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int WORD_W  = 10,
    parameter int TIMEOUT = 64
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_valid,
    input  logic [WORD_W-1:0]            wr_data,
    output logic                         wr_ready,
    input  logic                         run,
    output logic                         stim_valid,
    output logic [7:0]                   stim_data,
    input  logic                         resp_valid,
    input  logic [7:0]                   resp_data,
    output logic [15:0]                  sig,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic                         timeout
`ifdef BIST_GOLDEN_CMP_EN
    ,
    input  logic [15:0]                  gold_sig,
    output logic                         pass
`endif
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    bist_state_e state, next_state;

    // Only the stimulus byte and compact flag are kept; the reserved bit is dropped on write.
    logic [8:0]         mem [DEPTH];
    logic [8:0]         cur_word;
    logic [CNT_W-1:0]   idx;
    logic [TMR_W-1:0]   timer;
    logic [7:0]         stim_hold;
    logic               reserved_unused;

    logic in_idle, start, clear_hit, wr_accept, ovf_hit, resp_hit, timer_expired;

    assign reserved_unused = wr_data[1];
    assign cur_word        = mem[idx[ADDR_W-1:0]];

    assign in_idle       = (state == IDLE);
    assign wr_ready      = in_idle && (count != CNT_W'(DEPTH));
    assign start         = in_idle && run;
    assign clear_hit     = in_idle && clear;
    assign wr_accept     = wr_valid && wr_ready && !clear;
    assign ovf_hit       = in_idle && wr_valid && !clear && (count == CNT_W'(DEPTH));
    assign resp_hit      = (state == WAIT) && resp_valid;
    assign timer_expired = (state == WAIT) && !resp_valid && (timer == TMR_W'(TIMEOUT - 1));

    assign stim_data = stim_valid ? cur_word[8:1] : stim_hold;

    // State register; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the strobe, busy and done outputs decoded from state.
    always_comb begin
        next_state = state;
        stim_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (idx == count) begin
                    next_state = FINISH;
                end else begin
                    stim_valid = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (resp_valid) begin
                    next_state = ISSUE;
                end else if (timer_expired) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word count: clear wins over a same-cycle write; only changes while idle.
    always_ff @(posedge clk) begin
        if (rst || clear_hit) begin
            count <= '0;
        end else if (wr_accept) begin
            count <= count + 1'b1;
        end
    end

    // Buffer write at the current count; contents survive clear and runs.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[count[ADDR_W-1:0]] <= {wr_data[STIM_MSB:STIM_LSB], wr_data[COMPACT_BIT]};
        end
    end

    // Replay index: restarts at each run, advances once per answered word.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            idx <= '0;
        end else if (resp_hit) begin
            idx <= idx + 1'b1;
        end
    end

    // Response watchdog: counts cycles spent in WAIT, restarts on every other state.
    always_ff @(posedge clk) begin
        if (rst || (state != WAIT)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Sticky overflow and timeout flags, cleared only by reset or an idle clear.
    always_ff @(posedge clk) begin
        if (rst || clear_hit) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
            if (timer_expired) begin
                timeout <= 1'b1;
            end
        end
    end

    // Holds the last issued stimulus byte between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_hold <= '0;
        end else if (stim_valid) begin
            stim_hold <= cur_word[8:1];
        end
    end

    bist_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (start),
        .step_en   (resp_hit && cur_word[0]),
        .data      (resp_data),
        .sig       (sig)
    );

`ifdef BIST_GOLDEN_CMP_EN
    // Golden compare verdict: cleared at run start, captured in FINISH with the final signature.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            pass <= 1'b0;
        end else if (state == FINISH) begin
            pass <= (sig == gold_sig) && !timeout;
        end
    end
`endif

endmodule

// File: doc/bist_vector_engine.md
# bist_vector_engine

Runtime BIST vector engine that sits directly downstream of the JTAG GETTEST data register and upstream of the RUNBIST signature readout. It buffers 10-bit test words captured by the TAP, and on a run command replays them to the device under test one at a time. It compacts the responses into a 16-bit MISR signature, which the TAP shifts out as the 16-bit RUNBIST data register.

## Interface
- DEPTH, 256: test-word buffer entries.
- WORD_W, 10: test-word width (fixed format below).
- TIMEOUT, 64: max clk cycles to wait for a DUT response.

Ports:
- clk  in  1  system clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  pulse; empties buffer, clears sticky flags.
- wr_valid  in  1  test word present (one pulse per TAP Update-DR, already in clk domain).
- wr_data  in  WORD_W  [9:2] stimulus byte, [1] reserved (ignored), [0] compact flag.
- wr_ready  out  1  high when IDLE and count < DEPTH.
- run  in  1  pulse; start replay (RUNBIST).
- stim_valid  out  1  one-cycle strobe per word.
- stim_data  out  8  stimulus byte; holds its value until the next strobe.
- resp_valid  in  1  DUT response strobe.
- resp_data  in  8  DUT response byte.
- sig  out  16  MISR signature.
- count  out  $clog2(DEPTH+1)  stored words.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- overflow  out  1  sticky; write attempted while full.
- timeout  out  1  sticky; response missing.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- Write handshake: accepted when wr_valid && wr_ready. The word is stored at index count, and count increments on the same edge.
- wr_valid while count == DEPTH sets overflow; the word is dropped.
- wr_valid while busy: the word is dropped silently, and no flag is set.
- clear in IDLE resets count, overflow and timeout. Buffer contents are not erased. clear while busy is ignored. clear and wr_valid in the same cycle: clear wins.
- run in IDLE: sig reseeds to 16'hFFFF, idx = 0, go to ISSUE. A word written in the same cycle is included. run while busy is ignored.
- ISSUE:
  - If idx == count, go to FINISH.
  - Otherwise drive stim_valid with buf[idx][9:2] and go to WAIT.
- WAIT:
  - On resp_valid: if buf[idx][0], MISR step with resp_data; otherwise sig is unchanged. Then idx+1 and go to ISSUE.
  - After TIMEOUT cycles without resp_valid: set timeout, do not update sig, go to FINISH (the run aborts).
- FINISH: pulse done, drop busy, go to IDLE.
- MISR step: s = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0); sig = s ^ {8'h00, resp_data}.
- resp_valid outside WAIT is ignored.
- The buffer is retained after a run, so a repeat run replays the same vectors.
- Reset values: all outputs 0 except sig = 16'hFFFF and wr_ready = 1. State returns to IDLE. Reset mid-run aborts immediately with no done pulse.

## Timing
- Write-to-count latency: 1 cycle.
- run to first stim_valid: 1 cycle (IDLE→ISSUE edge, strobe in ISSUE).
- Response at cycle k after the strobe: sig updates at edge k+1, and the next stim_valid follows 1 cycle later.
- Per-word cost is 2 + response latency cycles.
- Empty run: run → ISSUE → FINISH; done pulses 2 cycles after run.
- busy is high from the cycle after run through the FINISH cycle.
- sig is stable from done until the next run.

## Configuration
- BIST_GOLDEN_CMP_EN defined:
  - Adds input gold_sig [15:0] and output pass [0:0].
  - pass is registered in FINISH as (sig_final == gold_sig) && !timeout.
  - pass is held until the next run and cleared at run start.
- Undefined: neither port exists, and the signature is checked off-chip via the TAP.

## Structure
- bist_pkg holds:
  - state enum;
  - MISR_POLY = 16'h1021 and MISR_SEED = 16'hFFFF;
  - word field positions (STIM_MSB = 9, STIM_LSB = 2, COMPACT_BIT = 0).
- Sub-module bist_misr (16-bit, step-enable, seed-load) is natural and shared with a future boundary-scan compactor.
- The buffer is a simple 1W/1R register array in the top module.

## Test plan
- Reset, then run with empty buffer → done 2 cycles after run, sig = 16'hFFFF, no stim_valid.
- Write one word 10'h001 (stim 0x00, compact), run, respond 0x5A after 1 cycle → stim_data 0x00, sig = 16'hEF85.
- Same word with compact = 0 (10'h000), respond 0x5A → sig = 16'hFFFF, done asserted.
- Write DEPTH words, then one more → count = DEPTH, wr_ready 0, overflow 1; clear → count 0, overflow 0.
- One compacting word, DUT never responds → timeout 1 after TIMEOUT cycles, done pulse, sig = 16'hFFFF.
- With BIST_GOLDEN_CMP_EN, gold_sig = 16'hEF85 and the word 10'h001 / response 0x5A case → pass 1; gold_sig = 16'h0000 → pass 0.
